// File: rtl/pattern_det_pkg.sv
// Shared definitions for the serial pattern detector: FSM encodings, symbols, widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   state_t   - one-hot FSM encoding (UNCFG, HUNT, MATCH)
//   B, C      - symbol constants of the BBCBC-style pattern alphabet
//   len_width - width needed to hold a pattern length 0..max_len
package pattern_det_pkg;

  typedef enum logic [2:0] {
    UNCFG = 3'b001,
    HUNT  = 3'b010,
    MATCH = 3'b100
  } state_t;

  localparam logic B = 1'b1;
  localparam logic C = 1'b0;

  // A length of max_len itself must be representable, hence the +1.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
// Latency: count reflects inc_i/clr_i one cycle after the sampling edge.
// Backpressure: none; inc_i is taken every cycle it is high.
//
// Ports:
//   clk, rst - clock and synchronous active-high reset (clears the count)
//   clr_i    - synchronous clear, wins over inc_i
//   inc_i    - increment request
//   cnt_o    - current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + W'(1);
    end
  end

endmodule

// File: rtl/pattern_detector_param.sv
// Serial bit-pattern detector with runtime-loadable pattern, length and overlap mode.
// Latency: pattern_o rises the cycle after the edge accepting the completing bit.
// Backpressure: none; every valid_i bit is consumed (dropped while unconfigured).
//
// Ports:
//   clk, rst          - clock and synchronous active-high reset (loads DEF_* config)
//   valid_i, data_i   - serial data bit and its qualifier
//   cfg_valid_i       - one-cycle config load strobe with cfg_pattern_i/cfg_len_i/cfg_overlap_i
//   pattern_o         - registered match flag, one cycle per match
//   match_cnt_o       - saturating number of matches since reset/config
//   cfg_err_o         - one-cycle pulse when a config with an illegal length is rejected
//   configured_o      - a legal pattern is loaded
// MAX_LEN is expected to lie in 2..16.
module pattern_detector_param
  import pattern_det_pkg::*;
#(
  parameter int               MAX_LEN     = 8,
  parameter int               CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b00011010,
  parameter int               DEF_LEN     = 5,
  parameter bit               DEF_OVERLAP = 1'b0,
  localparam int              LEN_W       = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic               data_i,
  input  logic               cfg_valid_i,
  input  logic [MAX_LEN-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic               cfg_overlap_i,
  output logic               pattern_o,
  output logic [CNT_W-1:0]   match_cnt_o,
  output logic               cfg_err_o,
  output logic               configured_o
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] DEF_LEN_L = LEN_W'(DEF_LEN);
  // A zero default length means there is nothing to hunt for out of reset.
  localparam state_t RST_STATE = (DEF_LEN != 0) ? HUNT : UNCFG;

  state_t             state;
  state_t             state_nx;
  logic [MAX_LEN-1:0] pat;
  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] hist_nx;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_inc;
  logic               overlap;
  logic               cfg_ok;
  logic               cfg_bad;
  logic               accept;
  logic               match;

  always_comb begin
    cfg_ok  = cfg_valid_i && (cfg_len_i != '0) && (cfg_len_i <= MAX_LEN_L);
    cfg_bad = cfg_valid_i && !cfg_ok;

    // A legal config load swallows the data bit of the same cycle.
    accept  = valid_i && (state != UNCFG) && !cfg_ok;

    hist_nx  = {hist[MAX_LEN-2:0], data_i};
    fill_inc = (fill < len) ? fill + LEN_W'(1) : fill;

    // Only the low len bits of history/pattern take part in the compare;
    // the newest bit sits at [0], the oldest relevant one at [len-1].
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end

    match = accept && (fill_inc == len) && ((hist_nx & mask) == (pat & mask));

    state_nx = state;
    if (cfg_ok) begin
      state_nx = HUNT;
    end else begin
      unique case (state)
        UNCFG:       state_nx = UNCFG;
        HUNT, MATCH: state_nx = match ? MATCH : HUNT;
        default:     state_nx = UNCFG;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RST_STATE;
      hist      <= '0;
      fill      <= '0;
      pat       <= DEF_PATTERN;
      len       <= DEF_LEN_L;
      overlap   <= DEF_OVERLAP;
      cfg_err_o <= 1'b0;
    end else begin
      state     <= state_nx;
      cfg_err_o <= cfg_bad;
      if (cfg_ok) begin
        pat     <= cfg_pattern_i;
        len     <= cfg_len_i;
        overlap <= cfg_overlap_i;
        hist    <= '0;
        fill    <= '0;
      end else if (accept) begin
        hist <= hist_nx;
        // Non-overlap mode restarts the fill so the next match needs len fresh bits.
        fill <= (match && !overlap) ? '0 : fill_inc;
      end
    end
  end

  assign pattern_o    = (state == MATCH);
  assign configured_o = (state != UNCFG);

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cfg_ok),
    .inc_i (match),
    .cnt_o (match_cnt_o)
  );

endmodule
